// File: rtl/ex_pipe_stage.sv
// ex_pipe_stage: execute stage between ID and WB/MEM.
// Accepts one instruction per cycle over a give/get handshake and holds one
// result register towards WB. Supports LUI, AUIPC, OP-IMM and OP (RV32I ALU).
// Optional feature macro: EX_MUL_EN enables an iterative shift-add MUL unit
// (MUL_STEP_BITS multiplier bits per cycle) and the MUL_BUSY state.
module ex_pipe_stage #(
    parameter int BITSIZE       = 32,
    parameter int MUL_STEP_BITS = 1
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic               ID_EX_give_i,
    output logic               EX_ID_get_o,
    input  logic [31:0]        ID_EX_instruction_i,
    input  logic [BITSIZE-1:0] ID_EX_pc_i,
    input  logic [BITSIZE-1:0] ID_EX_rs1_i,
    input  logic [BITSIZE-1:0] ID_EX_rs2_i,
    input  logic               WB_EX_get_i,
    output logic               EX_WB_give_o,
    output logic [31:0]        EX_WB_instruction_o,
    output logic [BITSIZE-1:0] EX_WB_d_o,
    output logic               EX_WB_illegal_o
);

    localparam int SHW = $clog2(BITSIZE);

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_REG   = 7'b0110011;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FULL     = 2'd1
`ifdef EX_MUL_EN
        ,
        ST_MUL_BUSY = 2'd2
`endif
    } state_t;

    state_t r_state;
    state_t w_state_next;
    state_t w_accept_state;

    logic [6:0]         w_opcode;
    logic [2:0]         w_f3;
    logic [6:0]         w_f7;
    logic [3:0]         w_alu_op;
    logic [BITSIZE-1:0] w_alu_res;
    logic [BITSIZE-1:0] w_result;
    logic               w_illegal;
    logic               w_is_mul;
    logic [SHW-1:0]     w_shamt;
    logic               w_get;
    logic               w_accept;
    logic               w_drain;

    logic [31:0]        r_instr;
    logic [BITSIZE-1:0] r_d;
    logic               r_illegal;

    // Instruction fields that the execute stage never looks at.
    logic w_unused;
    assign w_unused = ^{ID_EX_instruction_i[24:15], ID_EX_instruction_i[11:7]};

    assign w_opcode = ID_EX_instruction_i[6:0];
    assign w_f3     = ID_EX_instruction_i[14:12];
    assign w_f7     = ID_EX_instruction_i[31:25];
    assign w_shamt  = ID_EX_rs2_i[SHW-1:0];

    // Immediate forms only use instr[30] to pick SRAI; register forms use it for SUB/SRA.
    assign w_alu_op = (w_opcode == OPC_REG) ? {ID_EX_instruction_i[30], w_f3}
                    : {(w_f3 == 3'b101) & ID_EX_instruction_i[30], w_f3};

    // RV32I ALU on operand A (rs1) and operand B (rs2 or immediate).
    always_comb begin
        w_alu_res = '0;
        casez (w_alu_op)
            4'b0000: w_alu_res = ID_EX_rs1_i + ID_EX_rs2_i;
            4'b1000: w_alu_res = ID_EX_rs1_i - ID_EX_rs2_i;
            4'b?001: w_alu_res = ID_EX_rs1_i << w_shamt;
            4'b?010: w_alu_res = {{(BITSIZE-1){1'b0}}, ($signed(ID_EX_rs1_i) < $signed(ID_EX_rs2_i))};
            4'b?011: w_alu_res = {{(BITSIZE-1){1'b0}}, (ID_EX_rs1_i < ID_EX_rs2_i)};
            4'b?100: w_alu_res = ID_EX_rs1_i ^ ID_EX_rs2_i;
            4'b0101: w_alu_res = ID_EX_rs1_i >> w_shamt;
            4'b1101: w_alu_res = $unsigned($signed(ID_EX_rs1_i) >>> w_shamt);
            4'b?110: w_alu_res = ID_EX_rs1_i | ID_EX_rs2_i;
            4'b?111: w_alu_res = ID_EX_rs1_i & ID_EX_rs2_i;
            default: w_alu_res = '0;
        endcase
    end

    // Opcode decode: select the single-cycle result, flag unsupported encodings, spot MUL.
    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        w_is_mul  = 1'b0;
        case (w_opcode)
            OPC_LUI:   w_result = ID_EX_rs2_i;
            OPC_AUIPC: w_result = ID_EX_pc_i + ID_EX_rs2_i;
            OPC_IMM:   w_result = w_alu_res;
            OPC_REG: begin
                if (w_f7 == 7'b0000000 || w_f7 == 7'b0100000) begin
                    w_result = w_alu_res;
`ifdef EX_MUL_EN
                end else if (w_f7 == 7'b0000001 && w_f3 == 3'b000) begin
                    w_is_mul = 1'b1;
`endif
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default:   w_illegal = 1'b1;
        endcase
    end

`ifdef EX_MUL_EN
    localparam int ITER  = BITSIZE / MUL_STEP_BITS;
    localparam int CNT_W = $clog2(ITER + 1);

    logic [BITSIZE-1:0] r_mul_a;
    logic [BITSIZE-1:0] r_mul_b;
    logic [BITSIZE-1:0] r_mul_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [BITSIZE-1:0] w_mul_partial;
    logic               w_mul_done;

    assign w_mul_partial  = r_mul_a * BITSIZE'(r_mul_b[MUL_STEP_BITS-1:0]);
    assign w_mul_done     = (r_state == ST_MUL_BUSY) && (r_cnt == CNT_W'(ITER));
    assign w_accept_state = w_is_mul ? ST_MUL_BUSY : ST_FULL;

    // Shift-add multiplier: load operands on accept, retire MUL_STEP_BITS of B per busy cycle.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_mul_acc <= '0;
            r_cnt     <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mul_a   <= ID_EX_rs1_i;
            r_mul_b   <= ID_EX_rs2_i;
            r_mul_acc <= '0;
            r_cnt     <= '0;
        end else if (r_state == ST_MUL_BUSY && r_cnt != CNT_W'(ITER)) begin
            r_mul_acc <= r_mul_acc + w_mul_partial;
            r_mul_a   <= r_mul_a << MUL_STEP_BITS;
            r_mul_b   <= r_mul_b >> MUL_STEP_BITS;
            r_cnt     <= r_cnt + CNT_W'(1);
        end
    end
`else
    logic w_unused_step;
    assign w_unused_step  = (MUL_STEP_BITS > 0) | w_is_mul;
    assign w_accept_state = ST_FULL;
`endif

    // Handshake and next-state logic; FULL can accept only in a cycle where WB drains it.
    always_comb begin
        w_get        = 1'b0;
        w_drain      = 1'b0;
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: w_get = 1'b1;
            ST_FULL: begin
                w_get   = WB_EX_get_i;
                w_drain = WB_EX_get_i;
            end
            default:  w_get = 1'b0;
        endcase
        if (reset_i) begin
            w_get = 1'b0;
        end
        w_accept = w_get & ID_EX_give_i;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) w_state_next = w_accept_state;
            end
            ST_FULL: begin
                if (w_drain) w_state_next = w_accept ? w_accept_state : ST_EMPTY;
            end
`ifdef EX_MUL_EN
            ST_MUL_BUSY: begin
                if (w_mul_done) w_state_next = ST_FULL;
            end
`endif
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) r_state <= ST_EMPTY;
        else         r_state <= w_state_next;
    end

    // Result register: written only on accept (slot empty or draining) or MUL completion.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_instr   <= '0;
            r_d       <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_instr   <= ID_EX_instruction_i;
            r_d       <= w_result;
            r_illegal <= w_illegal;
`ifdef EX_MUL_EN
        end else if (w_mul_done) begin
            r_d       <= r_mul_acc;
            r_illegal <= 1'b0;
`endif
        end
    end

    assign EX_ID_get_o         = w_get;
    assign EX_WB_give_o        = (r_state == ST_FULL);
    assign EX_WB_instruction_o = r_instr;
    assign EX_WB_d_o           = r_d;
    assign EX_WB_illegal_o     = r_illegal;

endmodule

// File: tb/tb_ex_pipe_stage.sv
// Directed testbench for ex_pipe_stage (BITSIZE=32, MUL_STEP_BITS=1).
module tb_ex_pipe_stage;

    logic        clk;
    logic        reset_i;
    logic        give_i;
    logic        get_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        wb_get_i;
    logic        give_o;
    logic [31:0] instr_o;
    logic [31:0] d_o;
    logic        illegal_o;

    int checks = 0;
    int errors = 0;

    ex_pipe_stage #(.BITSIZE(32), .MUL_STEP_BITS(1)) dut (
        .clk                 (clk),
        .reset_i             (reset_i),
        .ID_EX_give_i        (give_i),
        .EX_ID_get_o         (get_o),
        .ID_EX_instruction_i (instr_i),
        .ID_EX_pc_i          (pc_i),
        .ID_EX_rs1_i         (rs1_i),
        .ID_EX_rs2_i         (rs2_i),
        .WB_EX_get_i         (wb_get_i),
        .EX_WB_give_o        (give_o),
        .EX_WB_instruction_o (instr_o),
        .EX_WB_d_o           (d_o),
        .EX_WB_illegal_o     (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_op(input logic [6:0] hi, input logic [2:0] f3);
        return {hi, 5'd4, 5'd1, f3, 5'd3, 7'b0010011};
    endfunction

    function automatic logic [31:0] u_op(input logic [6:0] opc);
        return {20'h00002, 5'd3, opc};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for exactly one edge (caller ensures the stage can accept).
    task automatic run_op(input logic [31:0] ins, input logic [31:0] pc,
                          input logic [31:0] a, input logic [31:0] b);
        give_i  = 1'b1;
        instr_i = ins;
        pc_i    = pc;
        rs1_i   = a;
        rs2_i   = b;
        tick();
        give_i  = 1'b0;
    endtask

    task automatic drain;
        wb_get_i = 1'b1;
        tick();
        wb_get_i = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] addi;
        addi = i_op(7'd0, 3'b000);
        reset_i = 1'b1; give_i = 1'b0; wb_get_i = 1'b0;
        instr_i = '0; pc_i = '0; rs1_i = '0; rs2_i = '0;
        repeat (2) tick();
        checks++; if (get_o !== 1'b0) begin errors++; $display("FAIL reset_get got=%b exp=0", get_o); end
        checks++; if (give_o !== 1'b0) begin errors++; $display("FAIL reset_give got=%b exp=0", give_o); end
        checks++; if (d_o !== 32'h0) begin errors++; $display("FAIL reset_d got=%h exp=0", d_o); end
        checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", instr_o); end
        checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", illegal_o); end
        reset_i = 1'b0;
        #1;
        checks++; if (get_o !== 1'b1) begin errors++; $display("FAIL empty_get got=%b exp=1", get_o); end
        run_op(addi, 32'h0, 32'h0, 32'h5);
        $display("tx ADDI 0+5 -> d=%h give=%b", d_o, give_o);
        checks++; if (give_o !== 1'b1) begin errors++; $display("FAIL addi_give got=%b exp=1", give_o); end
        checks++; if (d_o !== 32'h5) begin errors++; $display("FAIL addi_d got=%h exp=00000005", d_o); end
        checks++; if (instr_o !== addi) begin errors++; $display("FAIL addi_instr got=%h exp=%h", instr_o, addi); end
        // Asynchronous reset in the middle of a cycle clears the held result at once.
        #2 reset_i = 1'b1;
        #1;
        $display("tx async reset -> give=%b d=%h", give_o, d_o);
        checks++; if (give_o !== 1'b0) begin errors++; $display("FAIL async_give got=%b exp=0", give_o); end
        checks++; if (d_o !== 32'h0) begin errors++; $display("FAIL async_d got=%h exp=0", d_o); end
        checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL async_instr got=%h exp=0", instr_o); end
        tick();
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [31:0] add_i;
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] ve [3];
        add_i = r_op(7'd0, 3'b000);
        va[0] = 32'd1;        vb[0] = 32'd2; ve[0] = 32'd3;
        va[1] = 32'd3;        vb[1] = 32'd4; ve[1] = 32'd7;
        va[2] = 32'hFFFFFFFF; vb[2] = 32'd1; ve[2] = 32'd0;
        wb_get_i = 1'b1;
        give_i   = 1'b1;
        instr_i  = add_i;
        for (int i = 0; i < 3; i++) begin
            rs1_i = va[i];
            rs2_i = vb[i];
            tick();
            $display("tx ADD %h+%h -> d=%h give=%b get=%b", va[i], vb[i], d_o, give_o, get_o);
            checks++; if (d_o !== ve[i]) begin errors++; $display("FAIL b2b_d[%0d] got=%h exp=%h", i, d_o, ve[i]); end
            checks++; if (give_o !== 1'b1) begin errors++; $display("FAIL b2b_give[%0d] got=%b exp=1", i, give_o); end
            checks++; if (get_o !== 1'b1) begin errors++; $display("FAIL b2b_get[%0d] got=%b exp=1", i, get_o); end
        end
        give_i = 1'b0;
        tick();
        checks++; if (give_o !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", give_o); end
        wb_get_i = 1'b0;
    endtask

    task automatic test_stall;
        logic [31:0] sub_i;
        sub_i = r_op(7'b0100000, 3'b000);
        wb_get_i = 1'b0;
        run_op(sub_i, 32'h0, 32'd10, 32'd3);
        give_i  = 1'b1;
        instr_i = r_op(7'd0, 3'b000);
        rs1_i   = 32'd1;
        rs2_i   = 32'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            $display("tx stall cycle %0d -> give=%b d=%h get=%b", i, give_o, d_o, get_o);
            checks++; if (give_o !== 1'b1) begin errors++; $display("FAIL stall_give[%0d] got=%b exp=1", i, give_o); end
            checks++; if (d_o !== 32'd7) begin errors++; $display("FAIL stall_d[%0d] got=%h exp=00000007", i, d_o); end
            checks++; if (instr_o !== sub_i) begin errors++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, instr_o, sub_i); end
            checks++; if (get_o !== 1'b0) begin errors++; $display("FAIL stall_get[%0d] got=%b exp=0", i, get_o); end
            @(posedge clk);
            #1;
        end
        give_i = 1'b0;
        drain();
        checks++; if (give_o !== 1'b0) begin errors++; $display("FAIL stall_no_accept got=%b exp=0", give_o); end
    endtask

    task automatic test_alu;
        logic [31:0] ins [13];
        logic [31:0] pc  [13];
        logic [31:0] a   [13];
        logic [31:0] b   [13];
        logic [31:0] e   [13];
        ins[0]  = i_op(7'b0100000, 3'b101); pc[0]  = 0;      a[0]  = 32'h80000000; b[0]  = 32'd4;        e[0]  = 32'hF8000000;
        ins[1]  = i_op(7'b0000000, 3'b101); pc[1]  = 0;      a[1]  = 32'h80000000; b[1]  = 32'd4;        e[1]  = 32'h08000000;
        ins[2]  = r_op(7'b0000000, 3'b010); pc[2]  = 0;      a[2]  = 32'hFFFFFFFF; b[2]  = 32'd1;        e[2]  = 32'd1;
        ins[3]  = r_op(7'b0000000, 3'b011); pc[3]  = 0;      a[3]  = 32'hFFFFFFFF; b[3]  = 32'd1;        e[3]  = 32'd0;
        ins[4]  = u_op(7'b0010111);         pc[4]  = 32'h100; a[4] = 32'h0;        b[4]  = 32'h2000;     e[4]  = 32'h2100;
        ins[5]  = u_op(7'b0110111);         pc[5]  = 32'h100; a[5] = 32'h0;        b[5]  = 32'h12345000; e[5]  = 32'h12345000;
        ins[6]  = r_op(7'b0000000, 3'b001); pc[6]  = 0;      a[6]  = 32'd1;        b[6]  = 32'd33;       e[6]  = 32'd2;
        ins[7]  = r_op(7'b0100000, 3'b000); pc[7]  = 0;      a[7]  = 32'd0;        b[7]  = 32'd1;        e[7]  = 32'hFFFFFFFF;
        ins[8]  = i_op(7'b0000000, 3'b100); pc[8]  = 0;      a[8]  = 32'hF0F0;     b[8]  = 32'hFF00;     e[8]  = 32'h0FF0;
        ins[9]  = r_op(7'b0000000, 3'b111); pc[9]  = 0;      a[9]  = 32'hF0F0;     b[9]  = 32'hFF00;     e[9]  = 32'hF000;
        ins[10] = r_op(7'b0000000, 3'b110); pc[10] = 0;      a[10] = 32'hF0F0;     b[10] = 32'hFF00;     e[10] = 32'hFFF0;
        ins[11] = i_op(7'b0100000, 3'b000); pc[11] = 0;      a[11] = 32'd5;        b[11] = 32'd3;        e[11] = 32'd8;
        ins[12] = r_op(7'b0100000, 3'b101); pc[12] = 0;      a[12] = 32'h80000000; b[12] = 32'h3F;       e[12] = 32'hFFFFFFFF;
        for (int i = 0; i < 13; i++) begin
            run_op(ins[i], pc[i], a[i], b[i]);
            $display("tx alu[%0d] instr=%h a=%h b=%h -> d=%h ill=%b", i, ins[i], a[i], b[i], d_o, illegal_o);
            checks++; if (d_o !== e[i]) begin errors++; $display("FAIL alu_d[%0d] got=%h exp=%h", i, d_o, e[i]); end
            checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL alu_illegal[%0d] got=%b exp=0", i, illegal_o); end
            checks++; if (give_o !== 1'b1) begin errors++; $display("FAIL alu_give[%0d] got=%b exp=1", i, give_o); end
            drain();
        end
    endtask

    task automatic test_illegal_mul;
        logic [31:0] bad_i;
        logic [31:0] mul_i;
        bad_i = 32'h0000007F;
        mul_i = r_op(7'b0000001, 3'b000);
        wb_get_i = 1'b0;
        rs1_i = 32'h1234;
        rs2_i = 32'h5678;
        run_op(bad_i, 32'h0, 32'h1234, 32'h5678);
        $display("tx opcode 7F -> d=%h ill=%b", d_o, illegal_o);
        checks++; if (illegal_o !== 1'b1) begin errors++; $display("FAIL bad_illegal got=%b exp=1", illegal_o); end
        checks++; if (d_o !== 32'h0) begin errors++; $display("FAIL bad_d got=%h exp=0", d_o); end
        checks++; if (give_o !== 1'b1) begin errors++; $display("FAIL bad_give got=%b exp=1", give_o); end
        drain();
        run_op(r_op(7'b0000010, 3'b000), 32'h0, 32'd1, 32'd1);
        checks++; if (illegal_o !== 1'b1) begin errors++; $display("FAIL f7_illegal got=%b exp=1", illegal_o); end
        drain();
`ifdef EX_MUL_EN
        begin
            int lat;
            int bad_get;
            lat = -1;
            bad_get = 0;
            run_op(mul_i, 32'h0, 32'd6, 32'd7);
            for (int k = 1; k <= 60; k++) begin
                if (get_o !== 1'b0) bad_get++;
                @(posedge clk);
                #1;
                if (give_o === 1'b1) begin
                    lat = k;
                    break;
                end
            end
            $display("tx MUL 6*7 -> d=%h latency=%0d", d_o, lat);
            checks++; if (lat != 33) begin errors++; $display("FAIL mul_latency got=%0d exp=33", lat); end
            checks++; if (bad_get != 0) begin errors++; $display("FAIL mul_get_busy got=%0d exp=0", bad_get); end
            checks++; if (d_o !== 32'd42) begin errors++; $display("FAIL mul_d got=%h exp=0000002a", d_o); end
            checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL mul_illegal got=%b exp=0", illegal_o); end
            drain();
            run_op(r_op(7'b0000001, 3'b001), 32'h0, 32'd6, 32'd7);
            checks++; if (illegal_o !== 1'b1) begin errors++; $display("FAIL mulh_illegal got=%b exp=1", illegal_o); end
            drain();
        end
`else
        run_op(mul_i, 32'h0, 32'd6, 32'd7);
        $display("tx MUL 6*7 (no multiplier) -> d=%h ill=%b", d_o, illegal_o);
        checks++; if (give_o !== 1'b1) begin errors++; $display("FAIL mul_give got=%b exp=1", give_o); end
        checks++; if (illegal_o !== 1'b1) begin errors++; $display("FAIL mul_illegal got=%b exp=1", illegal_o); end
        checks++; if (d_o !== 32'h0) begin errors++; $display("FAIL mul_d got=%h exp=0", d_o); end
        drain();
`endif
    endtask

    task automatic test_reset_mul;
        int emitted;
        logic [31:0] ins;
`ifdef EX_MUL_EN
        ins = r_op(7'b0000001, 3'b000);
`else
        ins = r_op(7'b0000000, 3'b000);
`endif
        wb_get_i = 1'b0;
        run_op(ins, 32'h0, 32'd2, 32'd3);
        repeat (5) tick();
        #2 reset_i = 1'b1;
        #1;
        $display("tx reset during operation -> give=%b get=%b d=%h", give_o, get_o, d_o);
        checks++; if (give_o !== 1'b0) begin errors++; $display("FAIL rmul_give got=%b exp=0", give_o); end
        checks++; if (get_o !== 1'b0) begin errors++; $display("FAIL rmul_get got=%b exp=0", get_o); end
        checks++; if (d_o !== 32'h0) begin errors++; $display("FAIL rmul_d got=%h exp=0", d_o); end
        tick();
        reset_i  = 1'b0;
        wb_get_i = 1'b1;
        emitted  = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (give_o !== 1'b0) emitted++;
        end
        checks++; if (emitted != 0) begin errors++; $display("FAIL rmul_emitted got=%0d exp=0", emitted); end
        wb_get_i = 1'b0;
        run_op(i_op(7'd0, 3'b000), 32'h0, 32'h0, 32'h1);
        $display("tx ADDI 0+1 after reset -> d=%h give=%b", d_o, give_o);
        checks++; if (d_o !== 32'h1) begin errors++; $display("FAIL rmul_addi_d got=%h exp=00000001", d_o); end
        checks++; if (give_o !== 1'b1) begin errors++; $display("FAIL rmul_addi_give got=%b exp=1", give_o); end
        drain();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_alu();
        test_illegal_mul();
        test_reset_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
